picache_ctrl_nway: RTL and testbench



---
 rtl/picache_ctrl_nway_pkg.sv | 50 +++++
 rtl/picache_ctrl_nway_plru.sv | 42 ++++
 rtl/picache_ctrl_nway.sv | 170 +++++++++++++++++
 tb/tb_picache_ctrl_nway.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/picache_ctrl_nway_pkg.sv
// Shared cache mux types: address-select encoding and tree-PLRU helpers.
// The helpers work on a fixed 7-bit PLRU vector (up to 8 ways). Callers pass
// their real associativity as num_ways and use only the low num_ways-1 bits.
package picache_ctrl_nway_pkg;

   localparam int MAX_WAYS  = 8;
   localparam int MAX_NODES = MAX_WAYS - 1;

   typedef enum logic [1:0] {
      ADDR_CURR  = 2'd0,
      ADDR_PREV  = 2'd1,
      ADDR_FLUSH = 2'd2
   } addr_sel_t;

   // Walk from the root; bit=1 sends the victim into the lower-index subtree.
   // Leaves sit at heap indices num_ways-1 .. 2*num_ways-2.
   function automatic logic [2:0] plru_victim(input logic [MAX_NODES-1:0] lru,
                                              input int num_ways);
      int node;
      node = 0;
      for (int l = 0; l < 3; l++) begin
         if (node < num_ways - 1) begin
            node = lru[node[2:0]] ? (2 * node + 1) : (2 * node + 2);
         end
      end
      return 3'(node - (num_ways - 1));
   endfunction

   // Climb from the used way's leaf to the root, pointing every node on the
   // path at the sibling subtree. Off-path bits keep their incoming value.
   function automatic logic [MAX_NODES-1:0] plru_update(input logic [MAX_NODES-1:0] lru,
                                                        input logic [2:0] way,
                                                        input int num_ways);
      logic [MAX_NODES-1:0] res;
      int n;
      int p;
      res = lru;
      n   = int'(way) + num_ways - 1;
      for (int l = 0; l < 3; l++) begin
         if (n > 0) begin
            p = (n - 1) / 2;
            // a left child (odd index) makes the victim go right (bit=0)
            res[p[2:0]] = (n % 2 == 0);
            n = p;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/picache_ctrl_nway_plru.sv
// picache_plru_tree: combinational victim choice and PLRU update.
// Ports: valid_vec/hit_way/lru_in from the indexed set; victim is one-hot
// (lowest invalid way first, else the PLRU walk); lru_upd marks hit_way as MRU.
module picache_plru_tree
   import picache_ctrl_nway_pkg::*;
#(
   parameter int NUM_WAYS = 4
) (
   input  logic [NUM_WAYS-1:0] valid_vec,
   input  logic [NUM_WAYS-1:0] hit_way,
   input  logic [NUM_WAYS-2:0] lru_in,
   output logic [NUM_WAYS-1:0] victim,
   output logic [NUM_WAYS-2:0] lru_upd
);

   logic [2:0] hit_idx;
   logic       found;

   always_comb begin
      hit_idx = 3'd0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (hit_way[w]) hit_idx = 3'(w);
      end
   end

   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!valid_vec[w] && !found) begin
            victim[w] = 1'b1;
            found     = 1'b1;
         end
      end
      if (!found) begin
         victim = NUM_WAYS'(1) << plru_victim(MAX_NODES'(lru_in), NUM_WAYS);
      end
   end

   assign lru_upd = (NUM_WAYS-1)'(plru_update(MAX_NODES'(lru_in), hit_idx, NUM_WAYS));

endmodule

// File: rtl/picache_ctrl_nway.sv
// picache_ctrl_nway: N-way I-cache control FSM (IDLE/MISS/HIT[/FLUSH]).
// Ports: fetch handshake (mem_read/mem_resp/if_id_reg_load), fill port
// (pmem_read/pmem_resp), array controls (way_load, valid_datain, lru_*,
// addr_sel, flush_idx, load_stage_reg, read_array).
// Optional macro PICACHE_FLUSH_EN adds flush_req/flush_busy and the FLUSH
// sequence that clears valid and PLRU bits of every set.
module picache_ctrl_nway
   import picache_ctrl_nway_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int SET_BITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   output logic                mem_resp,
   output logic                pmem_read,
   input  logic                pmem_resp,
   input  logic                hit,
   input  logic [NUM_WAYS-1:0] hit_way,
   input  logic [NUM_WAYS-1:0] valid_vec,
   input  logic [NUM_WAYS-2:0] lru_in,
   input  logic                if_id_reg_load,
`ifdef PICACHE_FLUSH_EN
   input  logic                flush_req,
   output logic                flush_busy,
`endif
   output logic [NUM_WAYS-1:0] way_load,
   output logic                valid_datain,
   output logic                lru_load,
   output logic [NUM_WAYS-2:0] lru_out,
   output logic [1:0]          addr_sel,
   output logic [SET_BITS-1:0] flush_idx,
   output logic                load_stage_reg,
   output logic                read_array
);

`ifdef PICACHE_FLUSH_EN
   typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_HIT, ST_FLUSH} state_t;
   logic                flush_pend;
   logic [SET_BITS-1:0] flush_cnt;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_HIT} state_t;
`endif

   state_t              state;
   logic [NUM_WAYS-1:0] victim;
   logic [NUM_WAYS-2:0] lru_upd;

   picache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
      .valid_vec (valid_vec),
      .hit_way   (hit_way),
      .lru_in    (lru_in),
      .victim    (victim),
      .lru_upd   (lru_upd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
`ifdef PICACHE_FLUSH_EN
         flush_pend <= 1'b0;
         flush_cnt  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
`ifdef PICACHE_FLUSH_EN
               if (flush_req) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= '0;
               end else
`endif
               if (mem_read) state <= hit ? ST_HIT : ST_MISS;
            end
            ST_MISS: begin
`ifdef PICACHE_FLUSH_EN
               // a flush seen during the fill waits for the line to land
               if (pmem_resp) begin
                  state      <= (flush_pend || flush_req) ? ST_FLUSH : ST_HIT;
                  flush_pend <= 1'b0;
                  flush_cnt  <= '0;
               end else begin
                  flush_pend <= flush_pend | flush_req;
               end
`else
               if (pmem_resp) state <= ST_HIT;
`endif
            end
            ST_HIT: begin
`ifdef PICACHE_FLUSH_EN
               if (flush_req) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= '0;
               end else
`endif
               if (!mem_read)  state <= ST_IDLE;
               else if (!hit)  state <= ST_MISS;
            end
`ifdef PICACHE_FLUSH_EN
            ST_FLUSH: begin
               if (flush_cnt == {SET_BITS{1'b1}}) state <= ST_IDLE;
               else                               flush_cnt <= flush_cnt + 1'b1;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are a function of state and the staged request so a hit can be
   // answered in the same cycle; rst forces the idle defaults immediately.
   always_comb begin
      mem_resp       = 1'b0;
      pmem_read      = 1'b0;
      way_load       = '0;
      valid_datain   = 1'b0;
      lru_load       = 1'b0;
      lru_out        = '0;
      addr_sel       = ADDR_CURR;
      flush_idx      = '0;
      load_stage_reg = 1'b1;
      read_array     = 1'b1;
`ifdef PICACHE_FLUSH_EN
      flush_busy     = 1'b0;
`endif
      if (!rst) begin
         case (state)
            ST_MISS: begin
               addr_sel       = ADDR_PREV;
               load_stage_reg = 1'b0;
               pmem_read      = 1'b1;
               if (pmem_resp) begin
                  way_load     = victim;
                  valid_datain = 1'b1;
               end
            end
            ST_HIT: begin
`ifdef PICACHE_FLUSH_EN
               if (flush_req) begin
                  load_stage_reg = 1'b0;
               end else
`endif
               if (mem_read && hit) begin
                  if (if_id_reg_load) begin
                     mem_resp = 1'b1;
                     lru_load = 1'b1;
                     lru_out  = lru_upd;
                  end else begin
                     load_stage_reg = 1'b0;
                     read_array     = 1'b0;
                  end
               end
            end
`ifdef PICACHE_FLUSH_EN
            ST_FLUSH: begin
               way_load       = '1;
               lru_load       = 1'b1;
               addr_sel       = ADDR_FLUSH;
               flush_idx      = flush_cnt;
               flush_busy     = 1'b1;
               load_stage_reg = 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_picache_ctrl_nway.sv
// Bench for picache_ctrl_nway: a 4-way and an 8-way instance share the
// control inputs; a behavioural model predicts every output each cycle and
// directed steps pin specific values.
module tb_picache_ctrl_nway;

`ifdef PICACHE_FLUSH_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif
   localparam int S_IDLE = 0, S_MISS = 1, S_HIT = 2, S_FLUSH = 3;
   localparam int NSETS = 8;
   localparam logic [31:0] RST_OUTS = 32'h0300_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, mem_read = 1'b0, pmem_resp = 1'b0, hit = 1'b0;
   logic       ld = 1'b0, flush_req = 1'b0;
   logic [3:0] hit_way4 = '0, valid4 = '0;
   logic [2:0] lru4 = '0;
   logic [7:0] hit_way8 = '0, valid8 = '0;
   logic [6:0] lru8 = '0;

   logic       mem_resp4, pmem_read4, valid_datain4, lru_load4, lsr4, ra4, flush_busy4;
   logic [3:0] way_load4;
   logic [2:0] lru_out4, flush_idx4;
   logic [1:0] addr_sel4;
   logic       mem_resp8, pmem_read8, valid_datain8, lru_load8, lsr8, ra8, flush_busy8;
   logic [7:0] way_load8;
   logic [6:0] lru_out8;
   logic [2:0] flush_idx8;
   logic [1:0] addr_sel8;

`ifndef PICACHE_FLUSH_EN
   assign flush_busy4 = 1'b0;
   assign flush_busy8 = 1'b0;
`endif

   picache_ctrl_nway #(.NUM_WAYS(4), .SET_BITS(3)) dut4 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp4),
      .pmem_read(pmem_read4), .pmem_resp(pmem_resp), .hit(hit), .hit_way(hit_way4),
      .valid_vec(valid4), .lru_in(lru4), .if_id_reg_load(ld),
`ifdef PICACHE_FLUSH_EN
      .flush_req(flush_req), .flush_busy(flush_busy4),
`endif
      .way_load(way_load4), .valid_datain(valid_datain4), .lru_load(lru_load4),
      .lru_out(lru_out4), .addr_sel(addr_sel4), .flush_idx(flush_idx4),
      .load_stage_reg(lsr4), .read_array(ra4));

   picache_ctrl_nway #(.NUM_WAYS(8), .SET_BITS(3)) dut8 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp8),
      .pmem_read(pmem_read8), .pmem_resp(pmem_resp), .hit(hit), .hit_way(hit_way8),
      .valid_vec(valid8), .lru_in(lru8), .if_id_reg_load(ld),
`ifdef PICACHE_FLUSH_EN
      .flush_req(flush_req), .flush_busy(flush_busy8),
`endif
      .way_load(way_load8), .valid_datain(valid_datain8), .lru_load(lru_load8),
      .lru_out(lru_out8), .addr_sel(addr_sel8), .flush_idx(flush_idx8),
      .load_stage_reg(lsr8), .read_array(ra8));

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input logic resp, input logic pr,
                                        input logic [7:0] wl, input logic vd,
                                        input logic ll, input logic [6:0] lo,
                                        input logic [1:0] as, input logic [2:0] fi,
                                        input logic lsr, input logic ra, input logic fb);
      return {5'b0, fb, ra, lsr, fi, as, lo, ll, vd, wl, pr, resp};
   endfunction

   // Victim: first invalid way, else descend halving the way range.
   function automatic int m_victim(input int n, input logic [7:0] vv, input logic [6:0] lru);
      int lo, hi, mid, node;
      for (int w = 0; w < n; w++) if (!vv[w]) return w;
      lo = 0; hi = n; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (lru[node[2:0]]) begin hi = mid; node = 2 * node + 1; end
         else                begin lo = mid; node = 2 * node + 2; end
      end
      return lo;
   endfunction

   // Update: descend toward the used way, each node pointing at the other half.
   function automatic logic [6:0] m_update(input int n, input int way, input logic [6:0] lru);
      logic [6:0] res;
      int lo, hi, mid, node;
      res = lru; lo = 0; hi = n; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (way < mid) begin res[node[2:0]] = 1'b0; hi = mid; node = 2 * node + 1; end
         else           begin res[node[2:0]] = 1'b1; lo = mid; node = 2 * node + 2; end
      end
      return res;
   endfunction

   function automatic int onehot_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] m_expect(input int n, input int st, input int cnt,
                                            input logic [7:0] vv, input logic [6:0] lru,
                                            input logic [7:0] hw);
      logic resp, pr, vd, ll, lsr, ra, fb;
      logic [7:0] wl;
      logic [6:0] lo;
      logic [1:0] as;
      logic [2:0] fi;
      resp = 0; pr = 0; vd = 0; ll = 0; lsr = 1; ra = 1; fb = 0;
      wl = '0; lo = '0; as = 2'd0; fi = '0;
      if (!rst) begin
         if (st == S_MISS) begin
            as = 2'd1; lsr = 0; pr = 1;
            if (pmem_resp) begin wl = 8'(1 << m_victim(n, vv, lru)); vd = 1; end
         end else if (st == S_HIT) begin
            if (FEN && flush_req) lsr = 0;
            else if (mem_read && hit) begin
               if (ld) begin resp = 1; ll = 1; lo = m_update(n, onehot_idx(hw), lru); end
               else    begin lsr = 0; ra = 0; end
            end
         end else if (st == S_FLUSH) begin
            wl = 8'((1 << n) - 1); ll = 1; as = 2'd2; fi = 3'(cnt); fb = 1; lsr = 0;
         end
      end
      return pack(resp, pr, wl, vd, ll, lo, as, fi, lsr, ra, fb);
   endfunction

   int m_st = S_IDLE, m_cnt = 0;
   bit m_pend = 0;

   always @(negedge clk) begin
      chk("dut4 outputs", pack(mem_resp4, pmem_read4, 8'(way_load4), valid_datain4, lru_load4,
          7'(lru_out4), addr_sel4, flush_idx4, lsr4, ra4, flush_busy4),
          m_expect(4, m_st, m_cnt, 8'(valid4), 7'(lru4), 8'(hit_way4)));
      chk("dut8 outputs", pack(mem_resp8, pmem_read8, way_load8, valid_datain8, lru_load8,
          lru_out8, addr_sel8, flush_idx8, lsr8, ra8, flush_busy8),
          m_expect(8, m_st, m_cnt, valid8, lru8, hit_way8));
      if (hit && (!$onehot(hit_way4) || !$onehot(hit_way8))) begin
         bad++;
         $display("FAIL onehot: hit_way4=%b hit_way8=%b with hit", hit_way4, hit_way8);
      end
      // advance model state
      if (rst) begin
         m_st = S_IDLE; m_pend = 0; m_cnt = 0;
      end else begin
         case (m_st)
            S_IDLE: if (FEN && flush_req) begin m_st = S_FLUSH; m_cnt = 0; end
                    else if (mem_read) m_st = hit ? S_HIT : S_MISS;
            S_MISS: if (pmem_resp) begin
                       m_st = (FEN && (m_pend || flush_req)) ? S_FLUSH : S_HIT;
                       m_pend = 0; m_cnt = 0;
                    end else m_pend = m_pend || (FEN && flush_req);
            S_HIT:  if (FEN && flush_req) begin m_st = S_FLUSH; m_cnt = 0; end
                    else if (!mem_read) m_st = S_IDLE;
                    else if (!hit) m_st = S_MISS;
            default: if (m_cnt == NSETS - 1) m_st = S_IDLE; else m_cnt++;
         endcase
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      next_cycle();
      @(negedge clk);
      chk("reset outs", pack(mem_resp4, pmem_read4, 8'(way_load4), valid_datain4, lru_load4,
          7'(lru_out4), addr_sel4, flush_idx4, lsr4, ra4, flush_busy4), RST_OUTS);
      next_cycle();
      rst = 0;

      // cold miss, fill 5 cycles later
      mem_read = 1; hit = 0; valid4 = '0; valid8 = '0;
      next_cycle();
      @(negedge clk); chk("miss pmem_read", 32'(pmem_read4), 32'd1);
      for (int i = 0; i < 3; i++) next_cycle();
      next_cycle(); pmem_resp = 1;
      @(negedge clk);
      chk("cold victim", 32'(way_load4), 32'h1);
      chk("fill valid_datain", 32'(valid_datain4), 32'd1);
      chk("no resp on fill", 32'(mem_resp4), 32'd0);
      next_cycle(); pmem_resp = 0; hit = 1; ld = 1; hit_way4 = 4'b0001; hit_way8 = 8'h01;
      valid4 = 4'b0001; valid8 = 8'h01;
      @(negedge clk);
      chk("resp after fill", 32'(mem_resp4), 32'd1);
      chk("pmem_read dropped", 32'(pmem_read4), 32'd0);
      next_cycle(); mem_read = 0; hit = 0; hit_way4 = '0; hit_way8 = '0;

      // all valid, PLRU victim then hit update
      next_cycle(); mem_read = 1; valid4 = 4'hf; valid8 = 8'hff; lru4 = 3'b011; lru8 = 7'b0000011;
      next_cycle(); pmem_resp = 1;
      @(negedge clk); chk("plru victim way0", 32'(way_load4), 32'h1);
      next_cycle(); pmem_resp = 0; hit = 1; hit_way4 = 4'b0001; hit_way8 = 8'h01;
      @(negedge clk);
      chk("lru_out hit way0", 32'(lru_out4), 32'h0);
      chk("lru_load on hit", 32'(lru_load4), 32'd1);
      next_cycle(); hit_way4 = 4'b0010; lru4 = 3'b000; hit_way8 = 8'h20; lru8 = 7'h00;
      @(negedge clk);
      chk("8way hit5 lru", 32'(lru_out8), 32'h21);
      chk("4way hit1 lru", 32'(lru_out4), 32'h2);

      // stall for 3 cycles, then accept
      for (int i = 0; i < 3; i++) begin
         next_cycle(); ld = 0;
         @(negedge clk);
         chk("stall no resp", 32'(mem_resp4), 32'd0);
         chk("stall read_array", 32'(ra4), 32'd0);
         chk("stall no lru", 32'(lru_load4), 32'd0);
      end
      next_cycle(); ld = 1;
      @(negedge clk); chk("resp after stall", 32'(mem_resp4), 32'd1);
      next_cycle(); mem_read = 0; hit = 0; hit_way4 = '0; hit_way8 = '0;

      // reset in the middle of a miss
      next_cycle(); mem_read = 1;
      next_cycle();
      @(negedge clk); chk("miss before rst", 32'(pmem_read4), 32'd1);
      next_cycle(); rst = 1;
      next_cycle(); rst = 0; mem_read = 0;
      @(negedge clk);
      chk("post rst pmem_read", 32'(pmem_read4), 32'd0);
      chk("post rst outs", pack(mem_resp4, pmem_read4, 8'(way_load4), valid_datain4, lru_load4,
          7'(lru_out4), addr_sel4, flush_idx4, lsr4, ra4, flush_busy4), RST_OUTS);

`ifdef PICACHE_FLUSH_EN
      // flush requested during a miss
      next_cycle(); mem_read = 1; hit = 0;
      next_cycle(); flush_req = 1;
      next_cycle(); flush_req = 0;
      next_cycle(); pmem_resp = 1;
      next_cycle(); pmem_resp = 0; mem_read = 0;
      for (int i = 0; i < NSETS; i++) begin
         @(negedge clk);
         chk("flush_idx", 32'(flush_idx4), 32'(i));
         chk("flush_busy", 32'(flush_busy4), 32'd1);
         chk("flush way_load", 32'(way_load4), 32'hf);
         next_cycle();
      end
      mem_read = 1;
      @(negedge clk); chk("flush done", 32'(flush_busy4), 32'd0);
      next_cycle();
      @(negedge clk); chk("miss after flush", 32'(pmem_read4), 32'd1);
      next_cycle(); pmem_resp = 1;
      next_cycle(); pmem_resp = 0; mem_read = 0;
`endif

      next_cycle();
      next_cycle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
